// File: rtl/imm_ext_arbiter_if.sv
// Requester/consumer bundle for the two-input immediate-extension arbiter.
// Optional ZERO_EXT_IMM_EN adds per-requester zero-extension selects.
interface imm_ext_arbiter_if;
  logic        req0Valid;
  logic        req1Valid;
  logic [12:0] req0Imm;
  logic [12:0] req1Imm;
  logic        req0Ready;
  logic        req1Ready;
  logic        outValid;
  logic [31:0] outData;
  logic        outId;
  logic        outReady;
`ifdef ZERO_EXT_IMM_EN
  logic        req0Zext;
  logic        req1Zext;
`endif

  modport master (
    output req0Valid, req1Valid, req0Imm, req1Imm, outReady,
`ifdef ZERO_EXT_IMM_EN
    output req0Zext, req1Zext,
`endif
    input  req0Ready, req1Ready, outValid, outData, outId
  );

  modport slave (
    input  req0Valid, req1Valid, req0Imm, req1Imm, outReady,
`ifdef ZERO_EXT_IMM_EN
    input  req0Zext, req1Zext,
`endif
    output req0Ready, req1Ready, outValid, outData, outId
  );
endinterface

// File: rtl/imm_ext_arbiter.sv
// Two-requester round-robin arbiter feeding a one-entry output stage that sign-extends
// a 13-bit immediate to 32 bits. Define ZERO_EXT_IMM_EN to allow per-request zero extension.
module imm_ext_arbiter #(
  parameter int unsigned PRIO_INIT = 0
) (
  input logic              clk,
  input logic              rst_n,
  imm_ext_arbiter_if.slave bus
);
  localparam int DATA_W = 32;
  localparam int IMM_W  = 13;

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t                   state;
  logic                     prioPtr;
  logic                     acceptOk;
  logic                     grant0;
  logic                     grant1;
  logic signed [IMM_W-1:0]  immSel_p0;
  logic signed [DATA_W-1:0] extData_p0;
`ifdef ZERO_EXT_IMM_EN
  logic                     zextSel_p0;
`endif

  function automatic logic signed [DATA_W-1:0] signExt(input logic signed [IMM_W-1:0] imm);
    return {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
  endfunction

`ifdef ZERO_EXT_IMM_EN
  function automatic logic signed [DATA_W-1:0] zeroExt(input logic signed [IMM_W-1:0] imm);
    return {{(DATA_W-IMM_W){1'b0}}, imm};
  endfunction
`endif

  // Grant decision: readies never look at the immediates, only at valids, pointer and stage.
  always_comb begin
    acceptOk = rst_n && ((state == EMPTY) || bus.outReady);
    grant0   = acceptOk && bus.req0Valid && (!bus.req1Valid || (prioPtr == 1'b0));
    grant1   = acceptOk && bus.req1Valid && (!bus.req0Valid || (prioPtr == 1'b1));
    immSel_p0 = grant1 ? bus.req1Imm : bus.req0Imm;
`ifdef ZERO_EXT_IMM_EN
    zextSel_p0 = grant1 ? bus.req1Zext : bus.req0Zext;
    extData_p0 = zextSel_p0 ? zeroExt(immSel_p0) : signExt(immSel_p0);
`else
    extData_p0 = signExt(immSel_p0);
`endif
  end

  assign bus.req0Ready = grant0;
  assign bus.req1Ready = grant1;

  // Output stage: a grant always (re)loads, so drain-and-refill costs no bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= EMPTY;
      bus.outValid <= 1'b0;
      bus.outData  <= '0;
      bus.outId    <= 1'b0;
      prioPtr      <= 1'(PRIO_INIT);
    end else begin
      if (grant0 || grant1) begin
        state        <= FULL;
        bus.outValid <= 1'b1;
        bus.outData  <= extData_p0;
        bus.outId    <= grant1;
        prioPtr      <= grant0;
      end else if ((state == FULL) && bus.outReady) begin
        state        <= EMPTY;
        bus.outValid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_imm_ext_arbiter.sv
// Directed bench for imm_ext_arbiter: stimulus pushes expected results into a queue,
// a negedge monitor pops and compares every accepted output.
module tb_imm_ext_arbiter;
  logic clk;
  logic rst_n;
  imm_ext_arbiter_if bus ();

  imm_ext_arbiter #(.PRIO_INIT(0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nApplied = 0;
  int nMiss    = 0;
  logic [32:0] expQ[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nApplied++;
    if (act !== exp) begin
      nMiss++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v0, input logic [12:0] i0,
                       input logic v1, input logic [12:0] i1, input logic ordy);
    bus.req0Valid = v0;
    bus.req0Imm   = i0;
    bus.req1Valid = v1;
    bus.req1Imm   = i1;
    bus.outReady  = ordy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: a result is consumed when outValid and outReady meet.
  always @(negedge clk) begin
    if (rst_n && bus.outValid && bus.outReady) begin
      if (expQ.size() == 0) begin
        nApplied++;
        nMiss++;
        $display("FAIL unexpected_out: got %h/%0d, expected none", bus.outData, bus.outId);
      end else begin
        logic [32:0] e;
        e = expQ.pop_front();
        chk("outData", bus.outData, e[31:0]);
        chk("outId", {31'd0, bus.outId}, {31'd0, e[32]});
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    drive(1'b1, 13'h0, 1'b1, 13'h0, 1'b1);
`ifdef ZERO_EXT_IMM_EN
    bus.req0Zext = 1'b0;
    bus.req1Zext = 1'b0;
`endif
    #3;
    chk("rst_outValid", {31'd0, bus.outValid}, 32'd0);
    chk("rst_outData", bus.outData, 32'h0);
    chk("rst_outId", {31'd0, bus.outId}, 32'd0);
    chk("rst_readies", {30'd0, bus.req1Ready, bus.req0Ready}, 32'd0);
    drive(1'b0, 13'h0, 1'b0, 13'h0, 1'b0);
    #4 rst_n = 1'b1;

    // Sign extension of a negative immediate
    drive(1'b1, 13'h1000, 1'b0, 13'h0, 1'b1);
    #1 chk("neg_ready0", {31'd0, bus.req0Ready}, 32'd1);
    expQ.push_back({1'b0, 32'hFFFFF000});
    tick();

    // Positive immediate from requester 1
    drive(1'b0, 13'h0, 1'b1, 13'h0FFF, 1'b1);
    expQ.push_back({1'b1, 32'h00000FFF});
    tick();

    // Contention: alternates 0,1,0,1 one per cycle
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 13'h0001, 1'b1, 13'h1FFF, 1'b1);
      #1 chk("cont_grant", {30'd0, bus.req1Ready, bus.req0Ready}, (i % 2 == 0) ? 32'd1 : 32'd2);
      if (i % 2 == 0) expQ.push_back({1'b0, 32'h00000001});
      else            expQ.push_back({1'b1, 32'hFFFFFFFF});
      tick();
    end

    // Backpressure for 3 cycles while both requesters wait
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 13'h0001, 1'b1, 13'h1FFF, 1'b0);
      #1 chk("bp_readies", {30'd0, bus.req1Ready, bus.req0Ready}, 32'd0);
      @(negedge clk);
      chk("bp_outValid", {31'd0, bus.outValid}, 32'd1);
      chk("bp_outData", bus.outData, 32'hFFFFFFFF);
      chk("bp_outId", {31'd0, bus.outId}, 32'd1);
      tick();
    end
    drive(1'b1, 13'h0001, 1'b1, 13'h1FFF, 1'b1);
    #1 chk("release_grant", {30'd0, bus.req1Ready, bus.req0Ready}, 32'd1);
    expQ.push_back({1'b0, 32'h00000001});
    tick();
    drive(1'b0, 13'h0, 1'b0, 13'h0, 1'b1);
    tick();
    chk("drain_empty", {31'd0, bus.outValid}, 32'd0);

    // EMPTY ignores outReady=0
    drive(1'b1, 13'h0ABC, 1'b0, 13'h0, 1'b0);
    #1 chk("empty_ready0", {30'd0, bus.req1Ready, bus.req0Ready}, 32'd1);
    expQ.push_back({1'b0, 32'h00000ABC});
    tick();

    // Async reset while FULL discards the result and restores the pointer
    drive(1'b0, 13'h0, 1'b0, 13'h0, 1'b0);
    chk("pre_rst_full", {31'd0, bus.outValid}, 32'd1);
    #2 rst_n = 1'b0;
    expQ.delete();
    #1;
    chk("arst_outValid", {31'd0, bus.outValid}, 32'd0);
    chk("arst_outData", bus.outData, 32'h0);
    drive(1'b1, 13'h0005, 1'b1, 13'h1FFE, 1'b1);
    #1 chk("arst_readies", {30'd0, bus.req1Ready, bus.req0Ready}, 32'd0);
    tick();
    chk("arst_hold", {31'd0, bus.outValid}, 32'd0);
    #2 rst_n = 1'b1;
    #1 chk("ptr_init_grant", {30'd0, bus.req1Ready, bus.req0Ready}, 32'd1);
    expQ.push_back({1'b0, 32'h00000005});
    tick();
    drive(1'b0, 13'h0, 1'b0, 13'h0, 1'b1);
    tick();

`ifdef ZERO_EXT_IMM_EN
    drive(1'b1, 13'h1000, 1'b0, 13'h0, 1'b1);
    bus.req0Zext = 1'b1;
    expQ.push_back({1'b0, 32'h00001000});
    tick();
    bus.req0Zext = 1'b0;
    expQ.push_back({1'b0, 32'hFFFFF000});
    tick();
    drive(1'b0, 13'h0, 1'b0, 13'h0, 1'b1);
    tick();
`endif

    tick();
    tick();
    chk("queue_drained", expQ.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nApplied, nMiss);
    $finish;
  end
endmodule
